// File: rtl/smi_mem_req_type_router.sv
// smi_mem_req_type_router: splits one SMI request stream into read and write streams by frame type.
// Unknown frame types are swallowed whole and counted in a saturating drop counter.
module smi_mem_req_type_router #(
   parameter int DataIndexSize = 3,
   parameter logic [7:0] ReadReqId = 8'h02,
   parameter logic [7:0] WriteReqId = 8'h01,
   parameter int DataWidth = (1 << DataIndexSize) * 8
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 smiInReady,
   input  logic [7:0]           smiInEofc,
   input  logic [DataWidth-1:0] smiInData,
   output logic                 smiInStop,
   output logic                 smiRdReady,
   output logic [7:0]           smiRdEofc,
   output logic [DataWidth-1:0] smiRdData,
   input  logic                 smiRdStop,
   output logic                 smiWrReady,
   output logic [7:0]           smiWrEofc,
   output logic [DataWidth-1:0] smiWrData,
   input  logic                 smiWrStop,
   output logic [15:0]          dropCount
);
   typedef enum logic [1:0] {IDLE, RT_RD, RT_WR, DISC} state_t;
   state_t state_q, state_d;
   logic rd_v_q, rd_v_d, wr_v_q, wr_v_d;
   logic [7:0] rd_e_q, rd_e_d, wr_e_q, wr_e_d;
   logic [DataWidth-1:0] rd_d_q, rd_d_d, wr_d_q, wr_d_d;
   logic [15:0] drop_q, drop_d;
   logic rd_acc, wr_acc, is_rd, is_wr, stop, xfer, last, to_rd, to_wr, to_disc;
   always_comb begin
      rd_acc = ~rd_v_q | ~smiRdStop;
      wr_acc = ~wr_v_q | ~smiWrStop;
      is_rd = (smiInData[7:0] == ReadReqId);
      is_wr = (smiInData[7:0] == WriteReqId);
      stop = (state_q == RT_RD) ? ~rd_acc :
             (state_q == RT_WR) ? ~wr_acc :
             (state_q == IDLE) ? (is_rd ? ~rd_acc : is_wr ? ~wr_acc : 1'b0) : 1'b0;
      xfer = smiInReady & ~stop;
      last = |smiInEofc;
      to_rd = xfer & ((state_q == RT_RD) | ((state_q == IDLE) & is_rd));
      to_wr = xfer & ((state_q == RT_WR) | ((state_q == IDLE) & is_wr));
      to_disc = xfer & ((state_q == DISC) | ((state_q == IDLE) & ~is_rd & ~is_wr));
      state_d = state_q;
      if (xfer)
         state_d = last ? IDLE : (state_q != IDLE) ? state_q : is_rd ? RT_RD : is_wr ? RT_WR : DISC;
      // a register may drain and refill on the same edge, so refill wins over drain
      rd_v_d = to_rd | (rd_v_q & smiRdStop);
      rd_e_d = to_rd ? smiInEofc : rd_e_q;
      rd_d_d = to_rd ? smiInData : rd_d_q;
      wr_v_d = to_wr | (wr_v_q & smiWrStop);
      wr_e_d = to_wr ? smiInEofc : wr_e_q;
      wr_d_d = to_wr ? smiInData : wr_d_q;
      drop_d = drop_q + {15'd0, to_disc & last & ~&drop_q};
   end
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state_q <= IDLE;
         rd_v_q <= 1'b0;
         rd_e_q <= '0;
         rd_d_q <= '0;
         wr_v_q <= 1'b0;
         wr_e_q <= '0;
         wr_d_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         rd_v_q <= rd_v_d;
         rd_e_q <= rd_e_d;
         rd_d_q <= rd_d_d;
         wr_v_q <= wr_v_d;
         wr_e_q <= wr_e_d;
         wr_d_q <= wr_d_d;
         drop_q <= drop_d;
      end
   end
   assign smiInStop = srst | stop;
   assign smiRdReady = rd_v_q;
   assign smiRdEofc = rd_e_q;
   assign smiRdData = rd_d_q;
   assign smiWrReady = wr_v_q;
   assign smiWrEofc = wr_e_q;
   assign smiWrData = wr_d_q;
   assign dropCount = drop_q;
endmodule

// File: tb/tb_smi_mem_req_type_router.sv
// tb_smi_mem_req_type_router: directed and random frames checked against per-output expected flit queues.
module tb_smi_mem_req_type_router;
   localparam int DW = 64;
   logic clk = 1'b0;
   logic srst = 1'b1;
   logic smiInReady = 1'b0;
   logic [7:0] smiInEofc = '0;
   logic [DW-1:0] smiInData = '0;
   logic smiInStop;
   logic smiRdReady, smiWrReady;
   logic [7:0] smiRdEofc, smiWrEofc;
   logic [DW-1:0] smiRdData, smiWrData;
   logic smiRdStop = 1'b0;
   logic smiWrStop = 1'b0;
   logic [15:0] dropCount;

   smi_mem_req_type_router dut (
      .clk(clk), .srst(srst),
      .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
      .smiRdReady(smiRdReady), .smiRdEofc(smiRdEofc), .smiRdData(smiRdData), .smiRdStop(smiRdStop),
      .smiWrReady(smiWrReady), .smiWrEofc(smiWrEofc), .smiWrData(smiWrData), .smiWrStop(smiWrStop),
      .dropCount(dropCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] e;
      logic [DW-1:0] d;
   } flit_t;

   flit_t exp_rd[$];
   flit_t exp_wr[$];
   int total = 0;
   int bad = 0;
   int exp_drop = 0;
   int rd_seen = 0;
   int wr_seen = 0;
   bit rand_stop = 1'b0;
   bit in_x;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
      end
   endtask

   // one clock: sample transfers mid-cycle, score output flits, then advance past the edge
   task automatic tick();
      flit_t f;
      @(negedge clk);
      in_x = smiInReady & ~smiInStop;
      if (smiRdReady) rd_seen++;
      if (smiWrReady) wr_seen++;
      if (smiRdReady & ~smiRdStop) begin
         chk("rd_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) begin
            f = exp_rd.pop_front();
            chk("rd_eofc", smiRdEofc, f.e);
            chk("rd_data", smiRdData, f.d);
         end
      end
      if (smiWrReady & ~smiWrStop) begin
         chk("wr_expected", exp_wr.size() != 0, 1);
         if (exp_wr.size() != 0) begin
            f = exp_wr.pop_front();
            chk("wr_eofc", smiWrEofc, f.e);
            chk("wr_data", smiWrData, f.d);
         end
      end
      @(posedge clk);
      #1;
      if (rand_stop) begin
         smiRdStop = ($urandom_range(0, 2) == 0);
         smiWrStop = ($urandom_range(0, 2) == 0);
      end
   endtask

   task automatic idle(input int n);
      smiInReady = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_flit(input logic [7:0] e, input logic [DW-1:0] d, input int lat, output int n);
      n = 0;
      smiInReady = 1'b1;
      smiInEofc = e;
      smiInData = d;
      do begin
         tick();
         n++;
      end while (!in_x && n < 100);
      chk("in_accept", in_x, 1);
      if (lat == 1) begin
         chk("rd_lat_ready", smiRdReady, 1);
         chk("rd_lat_eofc", smiRdEofc, e);
         chk("rd_lat_data", smiRdData, d);
      end
      if (lat == 2) begin
         chk("wr_lat_ready", smiWrReady, 1);
         chk("wr_lat_eofc", smiWrEofc, e);
         chk("wr_lat_data", smiWrData, d);
      end
   endtask

   task automatic send_frame(input logic [7:0] ty, input int nf, input logic [7:0] last_e,
                             input bit lat, input int stall_at, input bit b2b);
      flit_t fl[$];
      flit_t f;
      int n;
      bit disc;
      disc = (ty != 8'h01) && (ty != 8'h02);
      for (int i = 0; i < nf; i++) begin
         f.d = {$urandom, $urandom};
         if (i == 0) f.d[7:0] = ty;
         f.e = (i == nf - 1) ? last_e : 8'd0;
         fl.push_back(f);
         if (ty == 8'h02) exp_rd.push_back(f);
         if (ty == 8'h01) exp_wr.push_back(f);
      end
      for (int i = 0; i < nf; i++) begin
         if (i == stall_at) begin
            smiRdStop = 1'b1;
            smiInReady = 1'b1;
            smiInEofc = fl[i].e;
            smiInData = fl[i].d;
            repeat (5) begin
               tick();
               chk("stall_in_stop", smiInStop, 1);
               chk("stall_rd_ready", smiRdReady, 1);
               chk("stall_rd_hold", smiRdData, fl[i-1].d);
               chk("stall_wr_idle", smiWrReady, 0);
            end
            smiRdStop = 1'b0;
         end
         send_flit(fl[i].e, fl[i].d, !lat ? 0 : (ty == 8'h02) ? 1 : (ty == 8'h01) ? 2 : 0, n);
         if (disc) chk("disc_no_stop", n, 1);
         if (disc && i == nf - 1 && exp_drop < 65535) exp_drop++;
         chk("drop_count", dropCount, exp_drop);
      end
      if (!b2b) smiInReady = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ty;
      int n;
      #2;
      chk("rst_in_stop", smiInStop, 1);
      chk("rst_rd_ready", smiRdReady, 0);
      chk("rst_wr_ready", smiWrReady, 0);
      chk("rst_rd_eofc", smiRdEofc, 0);
      chk("rst_wr_data", smiWrData, 0);
      chk("rst_drop", dropCount, 0);
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;

      rd_seen = 0;
      wr_seen = 0;
      send_frame(8'h02, 3, 8'd8, 1, -1, 0);
      idle(2);
      chk("t1_wr_never", wr_seen, 0);
      chk("t1_rd_cycles", rd_seen, 3);

      send_frame(8'h01, 1, 8'd4, 1, -1, 1);
      send_frame(8'h02, 2, 8'd8, 1, -1, 0);
      idle(2);

      rd_seen = 0;
      wr_seen = 0;
      send_frame(8'hFD, 4, 8'd8, 0, -1, 0);
      idle(2);
      chk("t3_rd_never", rd_seen, 0);
      chk("t3_wr_never", wr_seen, 0);
      chk("t3_drop_one", dropCount, 1);

      send_frame(8'h02, 3, 8'd8, 0, 2, 1);
      send_frame(8'h01, 2, 8'd3, 0, -1, 0);
      idle(3);

      send_flit(8'd0, {56'h123456_789abcde, 8'h01}, 2, n);
      smiInReady = 1'b1;
      smiInEofc = 8'd0;
      smiInData = 64'h5555_aaaa_0000_1111;
      #3;
      srst = 1'b1;
      #1;
      chk("arst_wr_ready", smiWrReady, 0);
      chk("arst_wr_eofc", smiWrEofc, 0);
      chk("arst_wr_data", smiWrData, 0);
      chk("arst_rd_ready", smiRdReady, 0);
      chk("arst_in_stop", smiInStop, 1);
      chk("arst_drop", dropCount, 0);
      smiInReady = 1'b0;
      exp_drop = 0;
      exp_rd.delete();
      exp_wr.delete();
      #2;
      srst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(8'h02, 3, 8'd5, 1, -1, 0);
      idle(3);
      chk("arst_queues", exp_rd.size() + exp_wr.size(), 0);

      rand_stop = 1'b1;
      repeat (300) begin
         n = $urandom_range(0, 2);
         ty = (n == 0) ? 8'h02 : (n == 1) ? 8'h01 : 8'($urandom_range(3, 255));
         send_frame(ty, $urandom_range(1, 5), 8'($urandom_range(1, 8)), 0, -1, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rand_stop = 1'b0;
      smiRdStop = 1'b0;
      smiWrStop = 1'b0;
      idle(5);
      chk("rand_rd_drained", exp_rd.size(), 0);
      chk("rand_wr_drained", exp_wr.size(), 0);

      smiInReady = 1'b1;
      smiInEofc = 8'd1;
      smiInData = 64'h0000_0000_0000_00FD;
      for (int i = 0; i < 65600; i++) begin
         @(negedge clk);
         if (smiInReady && !smiInStop && exp_drop < 65535) exp_drop++;
         @(posedge clk);
      end
      #1;
      smiInReady = 1'b0;
      chk("drop_model", dropCount, exp_drop);
      chk("drop_saturated", dropCount, 16'hFFFF);
      send_frame(8'hFD, 4, 8'd8, 0, -1, 0);
      idle(2);
      chk("drop_stays_sat", dropCount, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
